// File: rtl/sif_xa_arbiter.sv
// rtl/sif_xa_arbiter.sv - two-master arbiter for the SIF xa port
// SIF_ARB_BURST_EN: allow up to MAX_BURST back-to-back grants to one owner while the other waits
module sif_xa_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          xa_wr_s,
    output logic          xa_rd_s,
    output logic [AW-1:0] xa_addr,
    output logic [DW-1:0] xa_data_wr,
    input  logic [DW-1:0] xa_data_rd
);

    generate
        if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
            $error("MAX_BURST must be in 1..15");
        end
    endgenerate

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          rr_last, rr_last_nxt;
    logic          grant;
    logic          sel;
    logic          own_req, oth_req;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          t1_valid, t1_owner;
    logic          t2_valid, t2_owner;

`ifdef SIF_ARB_BURST_EN
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    logic [3:0] cnt, cnt_nxt;
`endif

    assign own_req = owner ? m1_req : m0_req;
    assign oth_req = owner ? m0_req : m1_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_last <= 1'b1;
`ifdef SIF_ARB_BURST_EN
            cnt     <= 4'd0;
`endif
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_last <= rr_last_nxt;
`ifdef SIF_ARB_BURST_EN
            cnt     <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        grant = 1'b0;
        sel   = owner;
`ifdef SIF_ARB_BURST_EN
        cnt_nxt = cnt;
`endif
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant = 1'b1;
                    sel   = (m0_req && m1_req) ? ~rr_last : m1_req;
`ifdef SIF_ARB_BURST_EN
                    cnt_nxt = 4'd1;
`endif
                end
            end
            OWN: begin
`ifdef SIF_ARB_BURST_EN
                if (own_req && cnt < BURST_LIM) begin
                    grant   = 1'b1;
                    sel     = owner;
                    cnt_nxt = cnt + 4'd1;
                end else if (oth_req) begin
                    grant   = 1'b1;
                    sel     = ~owner;
                    cnt_nxt = 4'd1;
                end else if (own_req) begin
                    // burst exhausted but nobody else wants the port: restart it without a bubble
                    grant   = 1'b1;
                    sel     = owner;
                    cnt_nxt = 4'd1;
                end
`else
                if (oth_req) begin
                    grant = 1'b1;
                    sel   = ~owner;
                end else if (own_req) begin
                    grant = 1'b1;
                    sel   = owner;
                end
`endif
            end
        endcase
        state_nxt   = grant ? OWN : IDLE;
        owner_nxt   = grant ? sel : owner;
        rr_last_nxt = grant ? sel : rr_last;
    end

    always_comb begin
        m0_gnt    = grant & ~sel & rst_n;
        m1_gnt    = grant & sel & rst_n;
        cmd_we    = sel ? m1_we : m0_we;
        cmd_addr  = sel ? m1_addr : m0_addr;
        cmd_wdata = sel ? m1_wdata : m0_wdata;
    end

    // Command issue plus a two-stage read tag pipeline that steers returns back to the issuer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa_wr_s    <= 1'b0;
            xa_rd_s    <= 1'b0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            t1_valid   <= 1'b0;
            t1_owner   <= 1'b0;
            t2_valid   <= 1'b0;
            t2_owner   <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            xa_wr_s    <= grant & cmd_we;
            xa_rd_s    <= grant & ~cmd_we;
            xa_addr    <= grant ? cmd_addr : '0;
            xa_data_wr <= grant ? cmd_wdata : '0;
            t1_valid   <= grant & ~cmd_we;
            t1_owner   <= sel;
            t2_valid   <= t1_valid;
            t2_owner   <= t1_owner;
            m0_rvalid  <= t2_valid & ~t2_owner;
            m1_rvalid  <= t2_valid & t2_owner;
            if (t2_valid && !t2_owner) begin
                m0_rdata <= xa_data_rd;
            end
            if (t2_valid && t2_owner) begin
                m1_rdata <= xa_data_rd;
            end
        end
    end

endmodule

// File: tb/tb_sif_xa_arbiter.sv
// tb/tb_sif_xa_arbiter.sv - randomized self-checking bench for sif_xa_arbiter
`timescale 1ns/1ps
module tb_sif_xa_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
`ifdef SIF_ARB_BURST_EN
    localparam int LIM = 4;
`else
    localparam int LIM = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          xa_wr_s, xa_rd_s;
    logic [AW-1:0] xa_addr;
    logic [DW-1:0] xa_data_wr, xa_data_rd;

    always #5 clk = ~clk;

    sif_xa_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
        .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd)
    );

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } cmd_t;

    cmd_t        q0[$], q1[$];
    int          gseq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          m_idle, m_last;
    int          m_run;
    bit          g_valid, g_m;
    logic        e_wr, e_rd;
    logic [15:0] e_addr, e_wdata, e_rdata0, e_rdata1;
    bit          ev_v[8];
    bit          ev_m[8];
    logic [15:0] ev_d[8];
    bit          n_pend;
    logic [15:0] n_addr, sif_xor;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        cmd_t c;
        c.req = req; c.we = we; c.addr = a; c.data = d;
        return c;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_last = 1'b1; m_run = 0;
        e_wr = 0; e_rd = 0; e_addr = 0; e_wdata = 0; e_rdata0 = 0; e_rdata1 = 0;
        for (int i = 0; i < 8; i++) ev_v[i] = 1'b0;
        n_pend = 1'b0;
    endtask

    // One clock cycle: inputs already applied; checks then advance the reference model.
    task automatic cycle();
        int          s;
        logic        we;
        logic [15:0] a, d;
        #1;
        if (!m0_req && !m1_req) begin
            g_valid = 1'b0;
        end else begin
            g_valid = 1'b1;
            if (m0_req != m1_req)  g_m = m1_req;
            else if (m_idle)       g_m = !m_last;
            else                   g_m = (m_run % LIM == 0) ? !m_last : m_last;
        end
        chk("m0_gnt", m0_gnt, g_valid && !g_m);
        chk("m1_gnt", m1_gnt, g_valid && g_m);
        if (m0_gnt === 1'b1)      gseq.push_back(0);
        else if (m1_gnt === 1'b1) gseq.push_back(1);
        chk("xa_wr_s", xa_wr_s, e_wr);
        chk("xa_rd_s", xa_rd_s, e_rd);
        chk("xa_addr", xa_addr, e_addr);
        chk("xa_data_wr", xa_data_wr, e_wdata);
        s = cyc % 8;
        if (ev_v[s]) begin
            if (ev_m[s]) e_rdata1 = ev_d[s];
            else         e_rdata0 = ev_d[s];
        end
        chk("m0_rvalid", m0_rvalid, ev_v[s] && !ev_m[s]);
        chk("m1_rvalid", m1_rvalid, ev_v[s] && ev_m[s]);
        chk("m0_rdata", m0_rdata, e_rdata0);
        chk("m1_rdata", m1_rdata, e_rdata1);
        ev_v[s] = 1'b0;
        n_pend = xa_rd_s;
        n_addr = xa_addr;
        if (g_valid) begin
            we = g_m ? m1_we : m0_we;
            a  = g_m ? m1_addr : m0_addr;
            d  = g_m ? m1_wdata : m0_wdata;
            e_wr = we; e_rd = !we; e_addr = a; e_wdata = d;
            if (!we) begin
                ev_v[(cyc + 3) % 8] = 1'b1;
                ev_m[(cyc + 3) % 8] = g_m;
                ev_d[(cyc + 3) % 8] = a ^ sif_xor;
            end
            m_run  = (!m_idle && g_m == m_last) ? (m_run % LIM) + 1 : 1;
            m_last = g_m;
            m_idle = 1'b0;
        end else begin
            e_wr = 0; e_rd = 0; e_addr = 0; e_wdata = 0;
            m_idle = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        xa_data_rd = n_pend ? (n_addr ^ sif_xor) : 16'($urandom);
    endtask

    task automatic step();
        cmd_t c0, c1;
        c0 = '0; c1 = '0;
        if (q0.size() > 0) c0 = q0[0];
        if (q1.size() > 0) c1 = q1[0];
        m0_req = c0.req; m0_we = c0.we; m0_addr = c0.addr; m0_wdata = c0.data;
        m1_req = c1.req; m1_we = c1.we; m1_addr = c1.addr; m1_wdata = c1.data;
        cycle();
        if (q0.size() > 0 && (!c0.req || (g_valid && !g_m))) void'(q0.pop_front());
        if (q1.size() > 0 && (!c1.req || (g_valid && g_m)))  void'(q1.pop_front());
    endtask

    task automatic drain(input int max_cyc);
        int b = 0;
        while ((q0.size() > 0 || q1.size() > 0) && b < max_cyc) begin
            step();
            b++;
        end
        chk("drain_timeout", q0.size() + q1.size(), 0);
        repeat (4) step();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_xa_wr_s", xa_wr_s, 0);
        chk("rst_xa_rd_s", xa_rd_s, 0);
        chk("rst_xa_addr", xa_addr, 0);
        chk("rst_xa_data_wr", xa_data_wr, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_hold_m0_rvalid", m0_rvalid, 0);
            chk("rst_hold_m1_rvalid", m1_rvalid, 0);
            chk("rst_hold_m0_gnt", m0_gnt, 0);
        end
        rst_n = 1'b1;
        xa_data_rd = 16'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        xa_data_rd = 0;
        sif_xor = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        do_reset(5);

        // Both masters request continuously from reset: m0 first, then blocks of LIM
        gseq.delete();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(mk(1'b1, 1'(i % 2), 16'(16'h0200 + i), 16'($urandom)));
            q1.push_back(mk(1'b1, 1'((i + 1) % 2), 16'(16'h0300 + i), 16'($urandom)));
        end
        drain(100);
        chk("burst_len", gseq.size(), 24);
        for (int i = 0; i < 24 && i < gseq.size(); i++)
            chk($sformatf("burst_seq[%0d]", i), gseq[i], (i / LIM) % 2);

        q0.push_back(mk(1'b1, 1'b1, 16'h1234, 16'hBEEF));
        drain(20);
        q1.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0000));
        drain(20);
        for (int i = 0; i < 3; i++) q0.push_back(mk(1'b1, 1'b0, 16'(16'h0100 + i), 16'h0));
        drain(20);

        // Reset in the cycle after the read strobe drops the in-flight return
        q1.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0000));
        step();
        step();
        m0_req = 1'b1;
        do_reset(3);
        m0_req = 1'b0;
        gseq.delete();
        q0.push_back(mk(1'b1, 1'b1, 16'h0042, 16'h1111));
        q1.push_back(mk(1'b1, 1'b1, 16'h0043, 16'h2222));
        drain(20);
        chk("post_rst_first_size", gseq.size(), 2);
        chk("post_rst_first", (gseq.size() > 0) ? gseq[0] : 9, 0);

        sif_xor = 16'($urandom);
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() == 0)
                q0.push_back(mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom)));
            if (q1.size() == 0)
                q1.push_back(mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom)));
            step();
        end
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
